tanh_backward: RTL and testbench

TANH_BACKWARD -- requirements
Module: tanh_backward

---
 rtl/tanh_backward.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_tanh_backward.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tanh_backward.sv
// Backward pass of tanh: result = grad * (1 - y*y), computed over three cycles
// on one shared single-precision multiplier and one adder, with a NaN fast path.
module tanh_backward #(
  parameter int NAN_CANON = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] y,
  input  logic [31:0] grad,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] op_count
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    SUB  = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic f_is_nan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction

  // Subnormal operands and results are flushed to signed zero; rounding is nearest-even.
  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    logic               sgn;
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [47:0]        prod;
    logic [23:0]        mant;
    logic               guard;
    logic               sticky;
    logic signed [10:0] e;
    logic [31:0]        r;
    sgn    = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    prod   = 48'd0;
    mant   = 24'd0;
    guard  = 1'b0;
    sticky = 1'b0;
    e      = 11'sd0;
    if (f_is_nan(a) || f_is_nan(b)) begin
      r = QNAN;
    end else if ((ea == 8'hFF) || (eb == 8'hFF)) begin
      if ((ea == 8'd0) || (eb == 8'd0)) begin
        r = QNAN;
      end else begin
        r = {sgn, 8'hFF, 23'd0};
      end
    end else if ((ea == 8'd0) || (eb == 8'd0)) begin
      r = {sgn, 31'd0};
    end else begin
      prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e    = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
      if (prod[47]) begin
        mant   = {1'b0, prod[46:24]};
        guard  = prod[23];
        sticky = |prod[22:0];
        e      = e + 11'sd1;
      end else begin
        mant   = {1'b0, prod[45:23]};
        guard  = prod[22];
        sticky = |prod[21:0];
      end
      if (guard && (sticky || mant[0])) begin
        mant = mant + 24'd1;
      end else begin
        mant = mant;
      end
      // A rounding carry leaves the fraction at zero and bumps the exponent.
      if (mant[23]) begin
        e = e + 11'sd1;
      end else begin
        e = e;
      end
      if (e >= 11'sd255) begin
        r = {sgn, 8'hFF, 23'd0};
      end else if (e <= 11'sd0) begin
        r = {sgn, 31'd0};
      end else begin
        r = {sgn, e[7:0], mant[22:0]};
      end
    end
    return r;
  endfunction

  // Operands carry guard/round/sticky bits below the 24-bit significand.
  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]         ea;
    logic [7:0]         eb;
    logic [31:0]        big;
    logic [31:0]        sml;
    logic [7:0]         dexp;
    logic [26:0]        mb;
    logic [26:0]        ms;
    logic [26:0]        mask;
    logic               stk;
    logic [27:0]        sum;
    logic [26:0]        m;
    logic [24:0]        rm;
    logic signed [10:0] e;
    logic [31:0]        r;
    ea   = a[30:23];
    eb   = b[30:23];
    big  = a;
    sml  = b;
    dexp = 8'd0;
    mb   = 27'd0;
    ms   = 27'd0;
    mask = 27'd0;
    stk  = 1'b0;
    sum  = 28'd0;
    m    = 27'd0;
    rm   = 25'd0;
    e    = 11'sd0;
    if (f_is_nan(a) || f_is_nan(b)) begin
      r = QNAN;
    end else if ((ea == 8'hFF) || (eb == 8'hFF)) begin
      if ((ea == 8'hFF) && (eb == 8'hFF) && (a[31] != b[31])) begin
        r = QNAN;
      end else if (ea == 8'hFF) begin
        r = a;
      end else begin
        r = b;
      end
    end else if ((ea == 8'd0) && (eb == 8'd0)) begin
      r = {a[31] & b[31], 31'd0};
    end else if (ea == 8'd0) begin
      r = b;
    end else if (eb == 8'd0) begin
      r = a;
    end else begin
      if (a[30:0] >= b[30:0]) begin
        big = a;
        sml = b;
      end else begin
        big = b;
        sml = a;
      end
      dexp = big[30:23] - sml[30:23];
      mb   = {1'b1, big[22:0], 3'b000};
      ms   = {1'b1, sml[22:0], 3'b000};
      if (dexp >= 8'd27) begin
        ms  = 27'd0;
        stk = 1'b1;
      end else begin
        mask = (27'd1 << dexp) - 27'd1;
        stk  = |(ms & mask);
        ms   = ms >> dexp;
      end
      ms[0] = ms[0] | stk;
      e     = $signed({3'b000, big[30:23]});
      if (big[31] == sml[31]) begin
        sum = {1'b0, mb} + {1'b0, ms};
        if (sum[27]) begin
          m = {sum[27:2], sum[1] | sum[0]};
          e = e + 11'sd1;
        end else begin
          m = sum[26:0];
        end
      end else begin
        m = mb - ms;
      end
      if (m == 27'd0) begin
        r = 32'd0;
      end else begin
        for (int i = 0; i < 26; i++) begin
          if (!m[26]) begin
            m = {m[25:0], 1'b0};
            e = e - 11'sd1;
          end else begin
            m = m;
          end
        end
        rm = {1'b0, m[26:3]};
        if (m[2] && (m[1] || m[0] || m[3])) begin
          rm = rm + 25'd1;
        end else begin
          rm = rm;
        end
        if (rm[24]) begin
          rm = rm >> 1;
          e  = e + 11'sd1;
        end else begin
          rm = rm;
        end
        if (e >= 11'sd255) begin
          r = {big[31], 8'hFF, 23'd0};
        end else if (e <= 11'sd0) begin
          r = {big[31], 31'd0};
        end else begin
          r = {big[31], e[7:0], rm[22:0]};
        end
      end
    end
    return r;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] y_r;
  logic [31:0] grad_r;
  logic [31:0] sq_r;
  logic [31:0] d_r;
  logic [31:0] result_r;
  logic        out_valid_r;
  logic [15:0] op_count_r;
  logic        accept_s;
  logic        nan_fast_s;
  logic        handshake_s;
  logic [31:0] mul_a_s;
  logic [31:0] mul_b_s;
  logic [31:0] mul_s;
  logic [31:0] add_s;

  assign in_ready    = (state_r == IDLE);
  assign accept_s    = in_valid & in_ready;
  assign nan_fast_s  = (NAN_CANON != 0) && (f_is_nan(y) || f_is_nan(grad));
  assign handshake_s = out_valid_r & out_ready;
  assign result      = result_r;
  assign out_valid   = out_valid_r;
  assign op_count    = op_count_r;

  // Shared multiplier operand select: y*y while squaring, grad*d otherwise.
  always_comb begin
    mul_a_s = grad_r;
    mul_b_s = d_r;
    if (state_r == SQ) begin
      mul_a_s = y_r;
      mul_b_s = y_r;
    end else begin
      mul_a_s = grad_r;
      mul_b_s = d_r;
    end
  end

  assign mul_s = f_mul(mul_a_s, mul_b_s);
  assign add_s = f_add(ONE, {~sq_r[31], sq_r[30:0]});

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = nan_fast_s ? DONE : SQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      SQ:   state_next_s = SUB;
      SUB:  state_next_s = MUL;
      MUL:  state_next_s = DONE;
      DONE: begin
        if (handshake_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, pipeline stages, output and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= 32'd0;
      grad_r      <= 32'd0;
      sq_r        <= 32'd0;
      d_r         <= 32'd0;
      result_r    <= 32'd0;
      out_valid_r <= 1'b0;
      op_count_r  <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            y_r    <= y;
            grad_r <= grad;
            if (nan_fast_s) begin
              result_r    <= QNAN;
              out_valid_r <= 1'b1;
            end
          end
        end
        SQ:  sq_r <= mul_s;
        SUB: d_r  <= add_s;
        MUL: begin
          result_r    <= mul_s;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (handshake_s) begin
            out_valid_r <= 1'b0;
            op_count_r  <= op_count_r + 16'd1;
          end
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_backward.sv
// Directed, table-driven bench for tanh_backward: arithmetic vectors, NaN fast
// path, output stall, mid-operation reset and a run of back-to-back transactions.
module tb_tanh_backward;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] y;
  logic [31:0] grad;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] op_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  tanh_backward #(.NAN_CANON(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .y        (y),
    .grad     (grad),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .result   (result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vy;
    logic [31:0] vg;
    logic [31:0] vexp;
    int          vlat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One transaction; when out_ready is high the handshake is checked as well.
  task automatic txn(input logic [31:0] ty, input logic [31:0] tg, input logic [31:0] texp,
                     input int tlat, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    y        = ty;
    grad     = tg;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    y        = $urandom;
    grad     = $urandom;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, tlat);
    chk({tag, " result"}, result, texp);
    if (out_ready) begin
      @(negedge clk);
      exp_cnt = exp_cnt + 16'd1;
      chk({tag, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, " op_count"}, {16'd0, op_count}, {16'd0, exp_cnt});
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 3};
    vecs[1] = '{32'h3F00_0000, 32'h3F80_0000, 32'h3F40_0000, 3};
    vecs[2] = '{32'hBF00_0000, 32'hC000_0000, 32'hBFC0_0000, 3};
    vecs[3] = '{32'h3F80_0000, 32'h4080_0000, 32'h0000_0000, 3};
    vecs[4] = '{32'h3F40_0000, 32'h3F80_0000, 32'h3EE0_0000, 3};
    vecs[5] = '{32'hC000_0000, 32'h3F00_0000, 32'hBFC0_0000, 3};
    vecs[6] = '{32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 3};
    vecs[7] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 0};
    vecs[8] = '{32'h3F00_0000, 32'h7F80_0001, 32'h7FC0_0000, 0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y         = 32'd0;
    grad      = 32'd0;

    // Asynchronous reset while the clock is low.
    #2 rst_n = 1'b0;
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    y        = vecs[0].vy;
    grad     = vecs[0].vg;
    rst_n    = 1'b1;

    for (int i = 0; i < 9; i++) begin
      txn(vecs[i].vy, vecs[i].vg, vecs[i].vexp, vecs[i].vlat, $sformatf("vec%0d", i));
    end

    // Consumer stall: output held, input pulses ignored.
    out_ready = 1'b0;
    txn(32'h3F00_0000, 32'h3F80_0000, 32'h3F40_0000, 3, "stall");
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      y        = 32'h3F80_0000;
      grad     = 32'h7FC0_0001;
      @(negedge clk);
      chk("stall out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall result", result, 32'h3F40_0000);
      chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 16'd1;
    chk("stall release out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall release op_count", {16'd0, op_count}, {16'd0, exp_cnt});
    repeat (4) begin
      @(negedge clk);
      chk("stall single out_valid", {31'd0, out_valid}, 32'd0);
      chk("stall single op_count", {16'd0, op_count}, {16'd0, exp_cnt});
    end

    // Reset while the subtract stage is in flight.
    @(negedge clk);
    y        = 32'h3F00_0000;
    grad     = 32'h3F80_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0;
    chk("abort in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("abort no out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("abort op_count after", {16'd0, op_count}, 32'd0);
    chk("abort in_ready after", {31'd0, in_ready}, 32'd1);

    // Back-to-back run with the consumer always ready.
    for (int i = 0; i < 200; i++) begin
      if (i[0]) begin
        txn(32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 3, "b2b");
      end else begin
        txn(32'hBF00_0000, 32'hC000_0000, 32'hBFC0_0000, 3, "b2b");
      end
    end
    chk("b2b final op_count", {16'd0, op_count}, 32'd200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
